// File: rtl/pipe_fetch_stage_pkg.sv
// cpu_pkg: shared pipeline types (IF/ID entry layout, NOP encoding) for fetch, decode and hazard logic
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;
endpackage

// File: rtl/pipe_fetch_stage_if.sv
// pipe_fetch_stage_if: fetch-stage bus; master = fetch stage, slave = hazard/decode/RAM side.
//   stall, redirect_valid, redirect_pc : control into fetch
//   imem_addr / imem_rdata             : combinational instruction RAM port
//   ifid_*                             : IF/ID register contents for decode
//   pc_debug, fetch_count, misalign_err: status
interface pipe_fetch_stage_if #(parameter int MEM_DEPTH = 256);
  localparam int AW = $clog2(MEM_DEPTH);
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          ifid_valid;
  logic [31:0]   ifid_instr;
  logic [31:0]   ifid_pc;
  logic [31:0]   ifid_pc_plus4;
  logic [31:0]   pc_debug;
  logic [31:0]   fetch_count;
  logic          misalign_err;
  modport master(
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, pc_debug, fetch_count, misalign_err
  );
  modport slave(
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, pc_debug, fetch_count, misalign_err
  );
endinterface

// File: rtl/pipe_fetch_stage_ifid_reg.sv
// ifid_reg: pipeline register for ifid_t with stall hold and flush-to-bubble.
//   clk, reset (async active-low), stall (hold), flush (bubble, pc fields kept), d -> q
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
    else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end
    else if (!stall) q <= d;
endmodule

// File: rtl/pipe_fetch_stage.sv
// pipe_fetch_stage: IF stage; holds PC, drives instruction RAM address, fills IF/ID.
//   clk, reset (async active-low), bus (master side of pipe_fetch_stage_if)
//   Priority per edge: reset > redirect (flushes IF/ID) > stall > advance.
module pipe_fetch_stage
  import cpu_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  pipe_fetch_stage_if.master bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  logic [31:0] pc;
  logic [31:0] fetch_count;
  logic        misalign_err;
  ifid_t       d;
  ifid_t       q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc           <= RESET_PC;
      fetch_count  <= 32'h0;
      misalign_err <= 1'b0;
    end
    else if (bus.redirect_valid) begin
      pc <= {bus.redirect_pc[31:2], 2'b00};
      if (|bus.redirect_pc[1:0]) misalign_err <= 1'b1;
    end
    else if (!bus.stall) begin
      pc          <= pc + 32'd4;
      fetch_count <= fetch_count + 32'd1;
    end
  always_comb d = '{valid: 1'b1, instr: bus.imem_rdata, pc: pc, pc_plus4: pc + 32'd4};
  ifid_reg u_ifid (
    .clk   (clk),
    .reset (reset),
    .stall (bus.stall),
    .flush (bus.redirect_valid),
    .d     (d),
    .q     (q)
  );
  assign bus.imem_addr     = pc[AW+1:2];
  assign bus.ifid_valid    = q.valid;
  assign bus.ifid_instr    = q.instr;
  assign bus.ifid_pc       = q.pc;
  assign bus.ifid_pc_plus4 = q.pc_plus4;
  assign bus.pc_debug      = pc;
  assign bus.fetch_count   = fetch_count;
  assign bus.misalign_err  = misalign_err;
endmodule

// File: tb/tb_pipe_fetch_stage.sv
// tb_pipe_fetch_stage: randomized and directed checks of the fetch stage against a behavioural model
module tb_pipe_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic m_v, m_mis;

  pipe_fetch_stage_if #(.MEM_DEPTH(256)) bus ();
  pipe_fetch_stage #(.MEM_DEPTH(256), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  assign bus.imem_rdata = mem[bus.imem_addr];

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return mem[(byte_addr / 4) % 256];
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
  endtask

  // drive one cycle's controls, clock it, advance the model, settle 1 time unit after the edge
  task automatic step(input logic st, input logic rv, input logic [31:0] rp);
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rp;
    @(posedge clk);
    if (rv) begin
      m_pc = rp - (rp % 4); m_v = 1'b0; m_instr = 32'h0;
      if (rp % 4 != 0) m_mis = 1'b1;
    end else if (!st) begin
      m_v = 1'b1; m_instr = word_at(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 4; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.pc_debug !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus.pc_debug); end
    n_cmp++; if (bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.ifid_valid); end
    n_cmp++; if (bus.ifid_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus.ifid_instr); end
    n_cmp++; if (bus.fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.fetch_count); end
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %b want 0", bus.misalign_err); end
    n_cmp++; if ({bus.ifid_pc, bus.ifid_pc_plus4} !== 64'h0) begin n_fail++; $display("FAIL reset_ifid_pcs got %h %h want 0 0", bus.ifid_pc, bus.ifid_pc_plus4); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [4];
    exp_instr = '{32'h20100001, 32'h20110002, 32'h20120003, 32'h20130004};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.ifid_instr !== exp_instr[i]) begin n_fail++; $display("FAIL seq_instr[%0d] got %h want %h", i, bus.ifid_instr, exp_instr[i]); end
      n_cmp++; if (bus.ifid_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.ifid_pc, i * 4); end
      n_cmp++; if (bus.ifid_pc_plus4 !== 32'(i * 4 + 4)) begin n_fail++; $display("FAIL seq_pc4[%0d] got %h want %h", i, bus.ifid_pc_plus4, i * 4 + 4); end
      n_cmp++; if (bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b want 1", i, bus.ifid_valid); end
    end
    n_cmp++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL seq_count got %0d want 4", bus.fetch_count); end
    n_cmp++; if (bus.pc_debug !== 32'h10) begin n_fail++; $display("FAIL seq_pcdbg got %h want 10", bus.pc_debug); end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      n_cmp++; if (bus.ifid_pc !== 32'h4 || bus.ifid_instr !== 32'h20110002 || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_ifid[%0d] got %h/%h/%b want 4/20110002/1", i, bus.ifid_pc, bus.ifid_instr, bus.ifid_valid); end
      n_cmp++; if (bus.pc_debug !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 8", i, bus.pc_debug); end
      n_cmp++; if (bus.fetch_count !== m_cnt) begin n_fail++; $display("FAIL stall_count[%0d] got %0d want %0d", i, bus.fetch_count, m_cnt); end
    end
    step(1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.ifid_pc !== 32'h8 || bus.ifid_instr !== 32'h20120003) begin n_fail++; $display("FAIL stall_resume got %h/%h want 8/20120003", bus.ifid_pc, bus.ifid_instr); end
    n_cmp++; if (bus.fetch_count !== m_cnt) begin n_fail++; $display("FAIL stall_resume_count got %0d want %0d", bus.fetch_count, m_cnt); end
  endtask

  task automatic test_redirect();
    logic [31:0] old_pc;
    step(1'b0, 1'b1, 32'h10);
    n_cmp++; if (bus.pc_debug !== 32'h10) begin n_fail++; $display("FAIL redir_setup got %h want 10", bus.pc_debug); end
    old_pc = bus.ifid_pc;
    step(1'b0, 1'b1, 32'h28);
    n_cmp++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0) begin n_fail++; $display("FAIL redir_flush got %b/%h want 0/0", bus.ifid_valid, bus.ifid_instr); end
    n_cmp++; if (bus.pc_debug !== 32'h28) begin n_fail++; $display("FAIL redir_pc got %h want 28", bus.pc_debug); end
    n_cmp++; if (bus.ifid_pc !== old_pc || bus.fetch_count !== m_cnt) begin n_fail++; $display("FAIL redir_hold got %h/%0d want %h/%0d", bus.ifid_pc, bus.fetch_count, old_pc, m_cnt); end
    step(1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.ifid_pc !== 32'h28 || bus.ifid_instr !== mem[10] || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL redir_fetch got %h/%h/%b want 28/%h/1", bus.ifid_pc, bus.ifid_instr, bus.ifid_valid, mem[10]); end
  endtask

  task automatic test_far_jump();
    step(1'b0, 1'b1, 32'h0040_0030);
    n_cmp++; if (bus.pc_debug !== 32'h0040_0030) begin n_fail++; $display("FAIL far_pc got %h want 00400030", bus.pc_debug); end
    n_cmp++; if (bus.imem_addr !== 8'd12) begin n_fail++; $display("FAIL far_addr got %0d want 12", bus.imem_addr); end
    step(1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.ifid_pc !== 32'h0040_0030 || bus.ifid_instr !== mem[12]) begin n_fail++; $display("FAIL far_ifid got %h/%h want 00400030/%h", bus.ifid_pc, bus.ifid_instr, mem[12]); end
    n_cmp++; if (bus.ifid_pc_plus4 !== 32'h0040_0034) begin n_fail++; $display("FAIL far_pc4 got %h want 00400034", bus.ifid_pc_plus4); end
  endtask

  task automatic test_redirect_stall();
    step(1'b1, 1'b1, 32'h40);
    n_cmp++; if (bus.ifid_valid !== 1'b0 || bus.pc_debug !== 32'h40) begin n_fail++; $display("FAIL rs_win got %b/%h want 0/40", bus.ifid_valid, bus.pc_debug); end
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL rs_mis_early got %b want 0", bus.misalign_err); end
    step(1'b0, 1'b1, 32'h42);
    n_cmp++; if (bus.pc_debug !== 32'h40 || bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL rs_misalign got %h/%b want 40/1", bus.pc_debug, bus.misalign_err); end
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h80);
    n_cmp++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL rs_sticky got %b want 1", bus.misalign_err); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.pc_debug !== 32'h0 || bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap got %h/%h/%h want 0/0/fffffffc", bus.pc_debug, bus.ifid_pc_plus4, bus.ifid_pc); end
    n_cmp++; if (bus.ifid_instr !== mem[255]) begin n_fail++; $display("FAIL wrap_instr got %h want %h", bus.ifid_instr, mem[255]); end
  endtask

  task automatic test_random();
    logic st, rv;
    logic [31:0] rp;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      step(st, rv, rp);
      n_cmp++;
      if ({bus.pc_debug, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc_plus4, bus.fetch_count, bus.misalign_err} !==
          {m_pc, m_v, m_instr, m_ipc, m_ipc4, m_cnt, m_mis}) begin
        n_fail++;
        $display("FAIL rand[%0d] got pc=%h v=%b i=%h ipc=%h ipc4=%h cnt=%0d mis=%b want pc=%h v=%b i=%h ipc=%h ipc4=%h cnt=%0d mis=%b",
          i, bus.pc_debug, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc_plus4, bus.fetch_count, bus.misalign_err,
          m_pc, m_v, m_instr, m_ipc, m_ipc4, m_cnt, m_mis);
      end
      n_cmp++; if (bus.imem_addr !== 8'((m_pc / 4) % 256)) begin n_fail++; $display("FAIL rand_addr[%0d] got %0d want %0d", i, bus.imem_addr, (m_pc / 4) % 256); end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 32'h42);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.pc_debug !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.fetch_count !== 32'h0) begin n_fail++; $display("FAIL async_reset got %h/%b/%0d want 0/0/0", bus.pc_debug, bus.ifid_valid, bus.fetch_count); end
    n_cmp++; if (bus.misalign_err !== 1'b0 || bus.ifid_instr !== 32'h0 || bus.ifid_pc !== 32'h0) begin n_fail++; $display("FAIL async_reset_rest got %b/%h/%h want 0/0/0", bus.misalign_err, bus.ifid_instr, bus.ifid_pc); end
    model_reset();
    bus.stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.ifid_instr !== 32'h20100001 || bus.ifid_pc !== 32'h0 || bus.fetch_count !== 32'd1) begin n_fail++; $display("FAIL post_reset got %h/%h/%0d want 20100001/0/1", bus.ifid_instr, bus.ifid_pc, bus.fetch_count); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h20100001; mem[1] = 32'h20110002; mem[2] = 32'h20120003; mem[3] = 32'h20130004;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_far_jump();
    test_redirect_stall();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
